// File: rtl/magnitude_estimator_mc_pkg.sv
// Shared definitions for the multi-channel alpha-max-plus-beta-min magnitude estimator.
package magnitude_estimator_mc_pkg;

    typedef enum logic [1:0] {
        MODE_B4     = 2'd0,
        MODE_B2     = 2'd1,
        MODE_B38    = 2'd2,
        MODE_A15_16 = 2'd3
    } mode_e;

    // Enabled clocks from an accepted input sample to validOut.
    localparam int STAGES = 3;

    function automatic int ch_width(input int num_channels);
        return (num_channels <= 1) ? 1 : $clog2(num_channels);
    endfunction

endpackage

// File: rtl/magnitude_estimator_mc_if.sv
// Sample-in / estimate-out bundle for magnitude_estimator_mc.
interface magnitude_estimator_mc_if #(
    parameter int DATA_WIDTH   = 18,
    parameter int NUM_CHANNELS = 4
) ();
    localparam int CH_WIDTH = magnitude_estimator_mc_pkg::ch_width(NUM_CHANNELS);

    // validIn qualifies a sample on every clock where enable is high; there is no
    // backpressure, and validOut qualifies the registered outputs the same way.
    logic                         enable;
    logic                         validIn;
    logic [CH_WIDTH-1:0]          channelIn;
    logic [1:0]                   modeSel;
    logic signed [DATA_WIDTH-1:0] dataInRe;
    logic signed [DATA_WIDTH-1:0] dataInIm;
    logic                         peakClear;
    logic                         validOut;
    logic [CH_WIDTH-1:0]          channelOut;
    logic [DATA_WIDTH:0]          dataOut;
    logic [DATA_WIDTH:0]          peakOut;

    modport master (
        output enable, validIn, channelIn, modeSel, dataInRe, dataInIm, peakClear,
        input  validOut, channelOut, dataOut, peakOut
    );

    modport slave (
        input  enable, validIn, channelIn, modeSel, dataInRe, dataInIm, peakClear,
        output validOut, channelOut, dataOut, peakOut
    );

endinterface

// File: rtl/magnitude_estimator_mc_abs_max_min.sv
// Two registered stages: absolute values, then max/min sort, with a pass-through sideband tag.
module magnitude_estimator_mc_abs_max_min #(
    parameter int DATA_WIDTH = 18,
    parameter int SIDE_WIDTH = 4
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic                         enable,
    input  logic                         valid_in,
    input  logic [SIDE_WIDTH-1:0]        side_in,
    input  logic signed [DATA_WIDTH-1:0] re_in,
    input  logic signed [DATA_WIDTH-1:0] im_in,
    output logic                         valid_out,
    output logic [SIDE_WIDTH-1:0]        side_out,
    output logic [DATA_WIDTH-1:0]        mx_out,
    output logic [DATA_WIDTH-1:0]        mn_out
);
    logic [DATA_WIDTH-1:0] abs_re, abs_im;
    logic                  s1_valid;
    logic [SIDE_WIDTH-1:0] s1_side;
    logic [DATA_WIDTH-1:0] s1_re, s1_im;

    // Negating the most negative value wraps to 2^(W-1), which is exact as unsigned.
    assign abs_re = re_in[DATA_WIDTH-1] ? $unsigned(-re_in) : $unsigned(re_in);
    assign abs_im = im_in[DATA_WIDTH-1] ? $unsigned(-im_in) : $unsigned(im_in);

    always_ff @(posedge clock) begin
        if (reset) begin
            s1_valid  <= 1'b0;
            s1_side   <= '0;
            s1_re     <= '0;
            s1_im     <= '0;
            valid_out <= 1'b0;
            side_out  <= '0;
            mx_out    <= '0;
            mn_out    <= '0;
        end else if (enable) begin
            s1_valid  <= valid_in;
            s1_side   <= side_in;
            s1_re     <= abs_re;
            s1_im     <= abs_im;
            valid_out <= s1_valid;
            side_out  <= s1_side;
            mx_out    <= (s1_re >= s1_im) ? s1_re : s1_im;
            mn_out    <= (s1_re >= s1_im) ? s1_im : s1_re;
        end
    end

endmodule

// File: rtl/magnitude_estimator_mc.sv
// Multi-channel, mode-selectable alpha-max-plus-beta-min magnitude estimator with per-channel peak hold.
module magnitude_estimator_mc
    import magnitude_estimator_mc_pkg::*;
#(
    parameter int DATA_WIDTH   = 18,
    parameter int NUM_CHANNELS = 4
) (
    input logic                     clock,
    input logic                     reset,
    magnitude_estimator_mc_if.slave bus
);
    localparam int CH_WIDTH   = ch_width(NUM_CHANNELS);
    localparam int SIDE_WIDTH = CH_WIDTH + 2;
    localparam logic [CH_WIDTH:0] CH_LIMIT = (CH_WIDTH + 1)'(NUM_CHANNELS);

    logic                  in_valid;
    logic                  s2_valid;
    logic [SIDE_WIDTH-1:0] s2_side;
    logic [DATA_WIDTH-1:0] s2_mx, s2_mn;
    logic [CH_WIDTH-1:0]   s2_ch;
    logic [1:0]            s2_mode;
    logic [DATA_WIDTH:0]   mx_e, mn_e, est, peak_cur, peak_new;
    logic [DATA_WIDTH:0]   peak [NUM_CHANNELS];
    logic                  valid_q;
    logic [CH_WIDTH-1:0]   channel_q;
    logic [DATA_WIDTH:0]   data_q, peak_q;

    // Out-of-range channel tags enter the pipeline as bubbles.
    assign in_valid = bus.validIn && ({1'b0, bus.channelIn} < CH_LIMIT);

    magnitude_estimator_mc_abs_max_min #(
        .DATA_WIDTH (DATA_WIDTH),
        .SIDE_WIDTH (SIDE_WIDTH)
    ) u_abs_max_min (
        .clock     (clock),
        .reset     (reset),
        .enable    (bus.enable),
        .valid_in  (in_valid),
        .side_in   ({bus.channelIn, bus.modeSel}),
        .re_in     (bus.dataInRe),
        .im_in     (bus.dataInIm),
        .valid_out (s2_valid),
        .side_out  (s2_side),
        .mx_out    (s2_mx),
        .mn_out    (s2_mn)
    );

    assign s2_ch   = s2_side[SIDE_WIDTH-1:2];
    assign s2_mode = s2_side[1:0];
    assign mx_e    = {1'b0, s2_mx};
    assign mn_e    = {1'b0, s2_mn};

    // Each shifted term truncates on its own before the sum.
    always_comb begin
        est = '0;
        case (mode_e'(s2_mode))
            MODE_B4:     est = mx_e + (mn_e >> 2);
            MODE_B2:     est = mx_e + (mn_e >> 1);
            MODE_B38:    est = mx_e + (mn_e >> 2) + (mn_e >> 3);
            MODE_A15_16: est = mx_e - (mx_e >> 4) + (mn_e >> 1) - (mn_e >> 5);
            default:     est = '0;
        endcase
    end

    assign peak_cur = peak[s2_ch];
    assign peak_new = (bus.peakClear || est > peak_cur) ? est : peak_cur;

    always_ff @(posedge clock) begin
        if (reset) begin
            valid_q   <= 1'b0;
            channel_q <= '0;
            data_q    <= '0;
            peak_q    <= '0;
            for (int i = 0; i < NUM_CHANNELS; i++) peak[i] <= '0;
        end else begin
            if (bus.enable) begin
                valid_q <= s2_valid;
                if (s2_valid) begin
                    channel_q <= s2_ch;
                    data_q    <= est;
                    peak_q    <= peak_new;
                end
            end
            // peakClear is honoured even while the pipeline is frozen.
            for (int i = 0; i < NUM_CHANNELS; i++) begin
                if (bus.enable && s2_valid && s2_ch == CH_WIDTH'(i)) peak[i] <= peak_new;
                else if (bus.peakClear)                                peak[i] <= '0;
            end
        end
    end

    assign bus.validOut   = valid_q;
    assign bus.channelOut = channel_q;
    assign bus.dataOut    = data_q;
    assign bus.peakOut    = peak_q;

endmodule

// File: tb/tb_magnitude_estimator_mc.sv
// Bench for magnitude_estimator_mc: spec vectors, peak/enable/reset sequences and random traffic.
module tb_magnitude_estimator_mc;
    import magnitude_estimator_mc_pkg::*;

    localparam int DW    = 18;
    localparam int NCH   = 4;
    localparam int CHW   = 2;
    localparam int EXP_W = 32 + CHW + DW + 1;

    typedef struct {
        logic signed [DW-1:0] re;
        logic signed [DW-1:0] im;
        logic [1:0]           mode;
        logic [CHW-1:0]       ch;
        logic [DW:0]          exp;
    } vec_t;

    logic clock;
    logic reset;

    magnitude_estimator_mc_if #(.DATA_WIDTH(DW), .NUM_CHANNELS(NCH)) bus ();

    magnitude_estimator_mc #(.DATA_WIDTH(DW), .NUM_CHANNELS(NCH)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    int checks = 0;
    int errors = 0;
    int en_cnt = 0;
    logic [EXP_W-1:0] exp_q[$];
    logic [DW:0]      obs_peak[$];
    logic [DW:0]      mp [NCH];
    logic             exp_valid = 1'b0;
    logic [CHW-1:0]   last_ch = '0;
    logic [DW:0]      last_data = '0;
    logic [DW:0]      last_peak = '0;
    vec_t             vecs [7];

    // clock / reset
    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, req, $time);
        end
    endtask

    function automatic int est_model(input int re, input int im, input int mode);
        int a, b, mx, mn;
        a  = (re < 0) ? -re : re;
        b  = (im < 0) ? -im : im;
        mx = (a > b) ? a : b;
        mn = (a > b) ? b : a;
        case (mode)
            0:       return mx + mn / 4;
            1:       return mx + mn / 2;
            2:       return mx + mn / 4 + mn / 8;
            default: return mx - mx / 16 + mn / 2 - mn / 32;
        endcase
    endfunction

    // driver tasks
    task automatic drive(input logic signed [DW-1:0] re, input logic signed [DW-1:0] im,
                         input logic [1:0] mode, input logic [CHW-1:0] ch,
                         input logic vld, input logic en, input logic clr, input logic [DW:0] exp);
        @(negedge clock);
        bus.dataInRe  = re;
        bus.dataInIm  = im;
        bus.modeSel   = mode;
        bus.channelIn = ch;
        bus.validIn   = vld;
        bus.enable    = en;
        bus.peakClear = clr;
        if (vld && en && !reset) exp_q.push_back({32'(en_cnt + STAGES), ch, exp});
    endtask

    task automatic drive_model(input logic signed [DW-1:0] re, input logic signed [DW-1:0] im,
                               input logic [1:0] mode, input logic [CHW-1:0] ch,
                               input logic vld, input logic en, input logic clr);
        drive(re, im, mode, ch, vld, en, clr, (DW + 1)'(est_model(int'(re), int'(im), int'(mode))));
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive('0, '0, 2'd0, '0, 1'b0, 1'b1, 1'b0, '0);
    endtask

    task automatic pulse_reset(input int n);
        @(negedge clock);
        reset       = 1'b1;
        bus.validIn = 1'b0;
        repeat (n) @(negedge clock);
        reset = 1'b0;
    endtask

    // scoreboard: model is advanced right after each rising edge
    always @(posedge clock) begin
        logic rst_s, en_s, clr_s, out_now;
        logic [EXP_W-1:0] item;
        logic [CHW-1:0]   c;
        logic [DW:0]      e;
        rst_s = reset;
        en_s  = bus.enable;
        clr_s = bus.peakClear;
        #1;
        out_now = 1'b0;
        if (rst_s) begin
            exp_q.delete();
            for (int i = 0; i < NCH; i++) mp[i] = '0;
            exp_valid = 1'b0;
            last_ch   = '0;
            last_data = '0;
            last_peak = '0;
        end else begin
            if (en_s) begin
                en_cnt++;
                while (exp_q.size() > 0 && int'(exp_q[0][EXP_W-1 -: 32]) < en_cnt) begin
                    item = exp_q.pop_front();
                    check("sample_lost", 64'(en_cnt), 64'(item[EXP_W-1 -: 32]));
                end
                exp_valid = (exp_q.size() > 0) && (int'(exp_q[0][EXP_W-1 -: 32]) == en_cnt);
                out_now   = exp_valid;
            end
            if (out_now) begin
                item = exp_q.pop_front();
                c    = item[DW+CHW : DW+1];
                e    = item[DW:0];
                if (clr_s) begin
                    for (int i = 0; i < NCH; i++) mp[i] = '0;
                    mp[c] = e;
                end else if (e > mp[c]) begin
                    mp[c] = e;
                end
                last_ch   = c;
                last_data = e;
                last_peak = mp[c];
                obs_peak.push_back(bus.peakOut);
            end else if (clr_s) begin
                for (int i = 0; i < NCH; i++) mp[i] = '0;
            end
        end
        check("validOut",   64'(bus.validOut),   64'(exp_valid));
        check("dataOut",    64'(bus.dataOut),    64'(last_data));
        check("channelOut", 64'(bus.channelOut), 64'(last_ch));
        check("peakOut",    64'(bus.peakOut),    64'(last_peak));
    end

    initial begin
        logic [DW:0] t4 [4];
        reset         = 1'b1;
        bus.enable    = 1'b1;
        bus.validIn   = 1'b0;
        bus.channelIn = '0;
        bus.modeSel   = 2'd0;
        bus.dataInRe  = '0;
        bus.dataInIm  = '0;
        bus.peakClear = 1'b0;
        repeat (3) @(negedge clock);
        reset = 1'b0;

        // reference values, all channel 0
        vecs[0] = '{re: 18'sd59,      im: 18'sd15683,   mode: 2'd0, ch: 2'd0, exp: 19'd15697};
        vecs[1] = '{re: 18'sd15683,   im: -18'sd15696,  mode: 2'd0, ch: 2'd0, exp: 19'd19616};
        vecs[2] = '{re: 18'sd15683,   im: -18'sd15696,  mode: 2'd2, ch: 2'd0, exp: 19'd21576};
        vecs[3] = '{re: 18'sd15683,   im: -18'sd15696,  mode: 2'd3, ch: 2'd0, exp: 19'd22066};
        vecs[4] = '{re: -18'sd123,    im: -18'sd9989,   mode: 2'd1, ch: 2'd0, exp: 19'd10050};
        vecs[5] = '{re: -18'sd131072, im: 18'sd0,       mode: 2'd0, ch: 2'd0, exp: 19'd131072};
        vecs[6] = '{re: -18'sd131072, im: -18'sd131072, mode: 2'd1, ch: 2'd0, exp: 19'd196608};
        obs_peak.delete();
        for (int i = 0; i < 7; i++)
            drive(vecs[i].re, vecs[i].im, vecs[i].mode, vecs[i].ch, 1'b1, 1'b1, 1'b0, vecs[i].exp);
        idle(5);
        check("peak_seq_len", 64'(obs_peak.size()), 64'd7);
        if (obs_peak.size() >= 2) begin
            check("peak_first",  64'(obs_peak[0]), 64'd15697);
            check("peak_second", 64'(obs_peak[1]), 64'd19616);
        end

        // interleaved channels with peakClear on the third output edge
        pulse_reset(2);
        obs_peak.delete();
        drive(18'sd100, 18'sd0,   2'd0, 2'd0, 1'b1, 1'b1, 1'b0, 19'd100);
        drive(18'sd500, 18'sd0,   2'd0, 2'd1, 1'b1, 1'b1, 1'b0, 19'd500);
        drive(18'sd50,  18'sd0,   2'd0, 2'd0, 1'b1, 1'b1, 1'b0, 19'd50);
        drive(18'sd0,   18'sd600, 2'd0, 2'd1, 1'b1, 1'b1, 1'b0, 19'd600);
        drive('0, '0, 2'd0, '0, 1'b0, 1'b1, 1'b1, '0);
        idle(5);
        t4[0] = 19'd100; t4[1] = 19'd500; t4[2] = 19'd50; t4[3] = 19'd600;
        check("peak_interleave_len", 64'(obs_peak.size()), 64'd4);
        for (int i = 0; i < 4 && i < obs_peak.size(); i++)
            check($sformatf("peak_interleave_%0d", i), 64'(obs_peak[i]), 64'(t4[i]));

        // enable low for 5 clocks mid-stream
        for (int i = 0; i < 16; i++)
            drive_model(DW'($urandom_range(0, (1 << DW) - 1)), DW'($urandom_range(0, (1 << DW) - 1)),
                        2'($urandom_range(0, 3)), 2'($urandom_range(0, NCH - 1)),
                        1'b1, (i < 5 || i >= 10), 1'b0);
        idle(5);

        // reset with three samples in flight, then fresh traffic
        for (int i = 0; i < 3; i++)
            drive_model(18'sd40000 + 18'(i), 18'sd7, 2'd0, 2'(i), 1'b1, 1'b1, 1'b0);
        pulse_reset(1);
        idle(5);
        drive(18'sd10,  18'sd0, 2'd0, 2'd0, 1'b1, 1'b1, 1'b0, 19'd10);
        drive(18'sd300, 18'sd0, 2'd0, 2'd2, 1'b1, 1'b1, 1'b0, 19'd300);
        idle(5);

        // random traffic
        for (int i = 0; i < 10000; i++)
            drive_model(DW'($urandom_range(0, (1 << DW) - 1)), DW'($urandom_range(0, (1 << DW) - 1)),
                        2'($urandom_range(0, 3)), 2'($urandom_range(0, NCH - 1)),
                        $urandom_range(0, 9) != 0, $urandom_range(0, 15) != 0,
                        $urandom_range(0, 63) == 0);
        idle(8);
        check("queue_drained", 64'(exp_q.size()), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
